// File: rtl/lfsr_uart_streamer.sv
// lfsr_uart_streamer: Galois LFSR word generator feeding a word FIFO that is
// drained by a byte-serialising 8N1 UART transmitter, all on clk_50.
module lfsr_uart_streamer #(
   parameter int                LFSR_W     = 16,
   parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
   parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
   parameter int                FIFO_DEPTH = 16,
   parameter int                GEN_DIV    = 6_250_000,
   parameter int                BAUD_DIV   = 434
) (
   input  logic                          clk_50,
   input  logic                          clr_n,
   input  logic                          enable,
   input  logic                          mode,
   input  logic                          step,
   output logic [LFSR_W-1:0]             lfsr_out,
   output logic                          fifo_full,
   output logic                          fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [7:0]                    drop_cnt,
   output logic                          tx,
   output logic                          tx_busy
);

   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int GW     = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;
   localparam int BW     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int NBYTES = LFSR_W / 8;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

   // ---------------- generation side ----------------
   logic [GW-1:0]     gen_cnt_reg;
   logic              step_q_reg;
   logic [LFSR_W-1:0] lfsr_reg;
   logic [LFSR_W-1:0] lfsr_shift;
   logic [LFSR_W-1:0] lfsr_nxt;
   logic              gen_tick;
   logic              advance;

   assign gen_tick = (gen_cnt_reg == GW'(GEN_DIV - 1));
   // Step mode reacts only to the 0->1 transition of the step level.
   assign advance  = enable & (mode ? (step & ~step_q_reg) : gen_tick);

   // Galois shift; an all-zero result would lock up, so reload the seed instead.
   always_comb begin
      lfsr_shift = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? TAPS : '0);
      lfsr_nxt   = (lfsr_shift == '0) ? SEED : lfsr_shift;
   end

   // Free-run divider (parked at 0 unless free-running), step edge register, LFSR state.
   always_ff @(posedge clk_50 or negedge clr_n) begin
      if (!clr_n) begin
         gen_cnt_reg <= '0;
         step_q_reg  <= 1'b0;
         lfsr_reg    <= SEED;
      end else begin
         step_q_reg <= step;
         if (!enable || mode || gen_tick)
            gen_cnt_reg <= '0;
         else
            gen_cnt_reg <= gen_cnt_reg + 1'b1;
         if (advance)
            lfsr_reg <= lfsr_nxt;
      end
   end

   assign lfsr_out = lfsr_reg;

   // ---------------- word FIFO ----------------
   logic [LFSR_W-1:0] mem [FIFO_DEPTH];
   logic [LFSR_W-1:0] rd_data_reg;
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [AW:0]       count_reg;
   logic [7:0]        drop_reg;
   logic              push;
   logic              pop;
   logic              drop;
   state_t            state_reg;
   state_t            state_next;

   assign fifo_full  = (count_reg == (AW+1)'(FIFO_DEPTH));
   assign fifo_empty = (count_reg == '0);
   assign fifo_count = count_reg;
   assign drop_cnt   = drop_reg;

   // The transmitter pops only from IDLE and never from an empty FIFO; a pop
   // in the same cycle frees the slot a push into a full FIFO needs.
   assign pop  = (state_reg == S_IDLE) && !fifo_empty;
   assign push = advance && (!fifo_full || pop);
   assign drop = advance && fifo_full && !pop;

   // Storage array with registered read: popped word is valid the next cycle.
   // When full with push+pop the pointers coincide and the read returns the old word.
   always_ff @(posedge clk_50) begin
      if (push)
         mem[wr_ptr_reg] <= lfsr_nxt;
      if (pop)
         rd_data_reg <= mem[rd_ptr_reg];
   end

   // Pointers (wrap naturally at the power-of-two depth), occupancy, saturating drop count.
   always_ff @(posedge clk_50 or negedge clr_n) begin
      if (!clr_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         drop_reg   <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (drop && (drop_reg != 8'hFF))
            drop_reg <= drop_reg + 1'b1;
      end
   end

   // ---------------- UART transmitter ----------------
   logic [BW-1:0]     baud_cnt_reg, baud_cnt_next;
   logic [2:0]        bit_idx_reg, bit_idx_next;
   logic [1:0]        byte_idx_reg, byte_idx_next;
   logic [LFSR_W-1:0] word_reg, word_next;
   logic              baud_end;

   assign baud_end = (baud_cnt_reg == BW'(BAUD_DIV - 1));

   // Transmitter state and datapath registers.
   always_ff @(posedge clk_50 or negedge clr_n) begin
      if (!clr_n) begin
         state_reg    <= S_IDLE;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         byte_idx_reg <= '0;
         word_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_idx_reg  <= bit_idx_next;
         byte_idx_reg <= byte_idx_next;
         word_reg     <= word_next;
      end
   end

   // Next-state and line decode; the word is shifted right one bit per data
   // bit, so after eight bits the next byte already sits at the bottom.
   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = baud_cnt_reg;
      bit_idx_next  = bit_idx_reg;
      byte_idx_next = byte_idx_reg;
      word_next     = word_reg;
      tx            = 1'b1;
      tx_busy       = 1'b1;
      case (state_reg)
         S_IDLE: begin
            tx_busy = 1'b0;
            if (!fifo_empty)
               state_next = S_LOAD;
         end
         S_LOAD: begin
            word_next     = rd_data_reg;
            byte_idx_next = '0;
            bit_idx_next  = '0;
            baud_cnt_next = '0;
            state_next    = S_START;
         end
         S_START: begin
            tx = 1'b0;
            if (baud_end) begin
               baud_cnt_next = '0;
               bit_idx_next  = '0;
               state_next    = S_DATA;
            end else begin
               baud_cnt_next = baud_cnt_reg + 1'b1;
            end
         end
         S_DATA: begin
            tx = word_reg[0];
            if (baud_end) begin
               baud_cnt_next = '0;
               word_next     = word_reg >> 1;
               if (bit_idx_reg == 3'd7)
                  state_next = S_STOP;
               else
                  bit_idx_next = bit_idx_reg + 1'b1;
            end else begin
               baud_cnt_next = baud_cnt_reg + 1'b1;
            end
         end
         S_STOP: begin
            tx = 1'b1;
            if (baud_end) begin
               baud_cnt_next = '0;
               if (byte_idx_reg == 2'(NBYTES - 1)) begin
                  state_next = S_IDLE;
               end else begin
                  byte_idx_next = byte_idx_reg + 1'b1;
                  state_next    = S_START;
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_lfsr_uart_streamer.sv
// tb_lfsr_uart_streamer: directed stimulus pushes expected UART bytes into a
// scoreboard queue; an independent line monitor decodes tx and checks them.
module tb_lfsr_uart_streamer;

   localparam int B = 4;   // BAUD_DIV of both instances

   logic        clk_50 = 1'b0;
   logic        clr_n  = 1'b0;
   logic        enable = 1'b0;
   logic        mode   = 1'b1;
   logic        step   = 1'b0;
   logic [15:0] lfsr_out;
   logic        fifo_full, fifo_empty;
   logic [2:0]  fifo_count;
   logic [7:0]  drop_cnt;
   logic        tx, tx_busy;

   logic        step8 = 1'b0;
   logic [7:0]  lfsr8;
   logic        full8, empty8, tx8, busy8;
   logic [1:0]  count8;
   logic [7:0]  drop8;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   logic        mon_en = 1'b1;
   logic [15:0] exp_w;

   always #5 clk_50 = ~clk_50;

   lfsr_uart_streamer #(
      .LFSR_W(16), .TAPS(16'hB400), .SEED(16'hACE1),
      .FIFO_DEPTH(4), .GEN_DIV(2), .BAUD_DIV(B)
   ) dut (
      .clk_50(clk_50), .clr_n(clr_n), .enable(enable), .mode(mode), .step(step),
      .lfsr_out(lfsr_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fifo_count(fifo_count), .drop_cnt(drop_cnt), .tx(tx), .tx_busy(tx_busy)
   );

   lfsr_uart_streamer #(
      .LFSR_W(8), .TAPS(8'hB8), .SEED(8'h01),
      .FIFO_DEPTH(2), .GEN_DIV(2), .BAUD_DIV(B)
   ) dut8 (
      .clk_50(clk_50), .clr_n(clr_n), .enable(1'b1), .mode(1'b1), .step(step8),
      .lfsr_out(lfsr8), .fifo_full(full8), .fifo_empty(empty8),
      .fifo_count(count8), .drop_cnt(drop8), .tx(tx8), .tx_busy(busy8)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   function automatic logic [15:0] lfsr16(input logic [15:0] s);
      logic [15:0] n;
      n = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
      return (n == 16'h0000) ? 16'hACE1 : n;
   endfunction

   task automatic push_word(input logic [15:0] w);
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
   endtask

   task automatic pulse();
      @(negedge clk_50); step = 1'b1;
      @(negedge clk_50); step = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int bound);
      int n = 0;
      do begin
         @(negedge clk_50);
         n++;
      end while (!(fifo_empty && !tx_busy) && n < bound);
      chk(name, {31'd0, fifo_empty && !tx_busy}, 32'd1);
      repeat (4) @(negedge clk_50);
   endtask

   // Line monitor: start bit seen at frame cycle 0, data sampled mid-bit.
   initial begin : monitor
      logic       active;
      int         cyc;
      logic [7:0] rx;
      logic [7:0] e;
      active = 1'b0;
      cyc    = 0;
      rx     = '0;
      forever begin
         @(negedge clk_50);
         if (!clr_n) begin
            active = 1'b0;
         end else if (!active) begin
            if (tx == 1'b0) begin
               active = 1'b1;
               cyc    = 0;
            end
         end else begin
            cyc++;
            if (cyc >= B + B/2 && cyc <= 8*B + B/2 && ((cyc - B - B/2) % B) == 0)
               rx[(cyc - B - B/2) / B] = tx;
            if (cyc == 9*B + B/2) begin
               active = 1'b0;
               if (mon_en) begin
                  chk("stop_bit", {31'd0, tx}, 32'd1);
                  if (exp_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_byte: got %0h expected none", rx);
                  end else begin
                     e = exp_q.pop_front();
                     chk("uart_byte", {24'd0, rx}, {24'd0, e});
                  end
               end
            end
         end
      end
   end

   initial begin : stim
      int busy_n;
      int period;
      exp_w = 16'hACE1;

      // Reset values
      repeat (3) @(negedge clk_50);
      chk("rst_lfsr", {16'd0, lfsr_out}, 32'hACE1);
      chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      clr_n = 1'b1;
      mode = 1'b1;
      enable = 1'b1;
      repeat (2) @(negedge clk_50);

      // Single step: value, start-bit latency and busy length
      exp_w = 16'hE270;
      push_word(exp_w);
      @(negedge clk_50); step = 1'b1;
      @(negedge clk_50); step = 1'b0;
      chk("step1_lfsr", {16'd0, lfsr_out}, 32'hE270);
      chk("step1_count", {29'd0, fifo_count}, 32'd1);
      busy_n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_50);
         if (i == 0) chk("load_tx_idle", {31'd0, tx}, 32'd1);
         if (i == 1) chk("start_bit_latency", {31'd0, tx}, 32'd0);
         if (!tx_busy) break;
         busy_n++;
      end
      // LOAD cycle plus two 40-clock frames
      chk("tx_busy_len", busy_n, 32'd81);
      wait_drain("drain_a", 100);

      exp_w = 16'h7138;
      push_word(exp_w);
      pulse();
      chk("step2_lfsr", {16'd0, lfsr_out}, 32'h7138);
      wait_drain("drain_b", 200);

      // Step held high for 100 clocks gives exactly one advance
      exp_w = 16'h389C;
      push_word(exp_w);
      @(negedge clk_50); step = 1'b1;
      repeat (100) @(negedge clk_50);
      step = 1'b0;
      chk("held_step_lfsr", {16'd0, lfsr_out}, 32'h389C);
      wait_drain("drain_c", 200);

      // Overflow: first word popped at once, four fill the FIFO, five dropped
      for (int k = 0; k < 10; k++) begin
         exp_w = lfsr16(exp_w);
         if (k < 5) push_word(exp_w);
         pulse();
         if (k == 4) chk("full_after5", {31'd0, fifo_full}, 32'd1);
      end
      chk("drop_after10", {24'd0, drop_cnt}, 32'd5);
      chk("count_full", {29'd0, fifo_count}, 32'd4);

      // Push on the same cycle as a pop while full
      busy_n = 0;
      while (tx_busy && busy_n < 300) begin
         @(negedge clk_50);
         busy_n++;
      end
      chk("pop_cycle_full", {31'd0, fifo_full}, 32'd1);
      step = 1'b1;
      exp_w = lfsr16(exp_w);
      push_word(exp_w);
      @(negedge clk_50);
      step = 1'b0;
      chk("bnd_count", {29'd0, fifo_count}, 32'd4);
      chk("bnd_full", {31'd0, fifo_full}, 32'd1);
      chk("bnd_drop", {24'd0, drop_cnt}, 32'd5);
      wait_drain("drain_d", 700);

      // Free-run: held while disabled, then two advances in four clocks
      mode = 1'b0;
      enable = 1'b0;
      repeat (20) @(negedge clk_50);
      chk("disabled_hold", {16'd0, lfsr_out}, {16'd0, exp_w});
      exp_w = lfsr16(exp_w);
      push_word(exp_w);
      exp_w = lfsr16(exp_w);
      push_word(exp_w);
      enable = 1'b1;
      repeat (4) @(negedge clk_50);
      enable = 1'b0;
      chk("freerun_lfsr", {16'd0, lfsr_out}, {16'd0, exp_w});
      wait_drain("drain_e", 300);

      // Saturating drop counter, then mid-frame asynchronous reset
      mon_en = 1'b0;
      enable = 1'b1;
      repeat (1000) @(negedge clk_50);
      chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
      repeat (100) @(negedge clk_50);
      chk("drop_sat_hold", {24'd0, drop_cnt}, 32'd255);
      chk("midframe_busy", {31'd0, tx_busy}, 32'd1);
      enable = 1'b0;
      #1 clr_n = 1'b0;
      #1;
      chk("mrst_tx", {31'd0, tx}, 32'd1);
      chk("mrst_busy", {31'd0, tx_busy}, 32'd0);
      chk("mrst_lfsr", {16'd0, lfsr_out}, 32'hACE1);
      chk("mrst_empty", {31'd0, fifo_empty}, 32'd1);
      chk("mrst_count", {29'd0, fifo_count}, 32'd0);
      chk("mrst_drop", {24'd0, drop_cnt}, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk_50);
      clr_n = 1'b1;
      repeat (50) @(negedge clk_50);
      mon_en = 1'b1;

      // Generator restarts from the seed after reset
      mode = 1'b1;
      enable = 1'b1;
      exp_w = 16'hE270;
      push_word(exp_w);
      pulse();
      chk("post_rst_lfsr", {16'd0, lfsr_out}, 32'hE270);
      wait_drain("drain_f", 200);
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      // 8-bit instance: maximal period of 255 returning to the seed
      period = 0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk_50); step8 = 1'b1;
         @(negedge clk_50); step8 = 1'b0;
         if (i == 1) chk("w8_first", {24'd0, lfsr8}, 32'hB8);
         if (lfsr8 == 8'h01 && period == 0) period = i;
      end
      chk("w8_period", period, 32'd255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
